// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, diff = (a - b - bin) mod 2^WIDTH, LSB first.
// Latency: start accepted at edge E0, bits at E1..E_WIDTH, done pulses in the cycle after E_WIDTH.
// Backpressure: none; start is honoured only in IDLE, ignored (not queued) while busy or done.
//
// Ports:
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   start            operation request, sampled only in IDLE
//   a, b, bin        minuend, subtrahend, borrow-in; captured on the accepting edge
//   busy             high while bits are being processed (RUN)
//   done             one-cycle pulse when diff/bout carry a new result
//   diff, bout       registered result and final borrow; hold until the next completion
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  // Partial result holds only the WIDTH-1 bits already produced; the last bit
  // is joined to it directly on the completing edge.
  logic [WIDTH-2:0] sr_q, sr_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_shift;

  // Full-subtractor on the current LSBs and the registered borrow.
  assign d_bit     = sa_q[0] ^ sb_q[0] ^ br_q;
  assign br_next   = (~sa_q[0] & sb_q[0]) | (~sa_q[0] & br_q) | (sb_q[0] & br_q);
  assign res_shift = {d_bit, sr_q};

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sa_d = sa_q >> 1;
        sb_d = sb_q >> 1;
        br_d = br_next;
        sr_d = res_shift[WIDTH-1:1];
        if (cnt_q == LAST) begin
          // Publish only complete results; counter parks at zero rather than wrapping.
          diff_d  = res_shift;
          bout_d  = br_next;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=4.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       bin4 = 1'b0;
  logic       busy4, done4, bout4;
  logic [3:0] diff4;

  int checks = 0;
  int errors = 0;
  int done_cnt8 = 0;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done8 === 1'b1) done_cnt8++;

  // Reference: plain widened unsigned arithmetic, top bit is the borrow.
  function automatic logic [8:0] ref_sub8(input logic [7:0] x, input logic [7:0] y, input logic bi);
    return {1'b0, x} - {1'b0, y} - {8'd0, bi};
  endfunction

  function automatic logic [4:0] ref_sub4(input logic [3:0] x, input logic [3:0] y, input logic bi);
    return {1'b0, x} - {1'b0, y} - {4'd0, bi};
  endfunction

  // Issues one start on the 8-bit instance, scrambles the operands right after,
  // and waits (bounded) for done. lat counts negedges after the start edge.
  task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input logic bv_in,
                        output logic [7:0] d, output logic bo, output int lat,
                        output int busy_cnt, output bit stable);
    logic [7:0] first;
    @(negedge clk);
    start8 = 1'b1; a8 = av; b8 = bv; bin8 = bv_in;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    lat = 1; busy_cnt = 0; stable = 1'b1; first = diff8;
    while (done8 !== 1'b1 && lat < 40) begin
      if (busy8 === 1'b1) busy_cnt++;
      if (diff8 !== first) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
    d = diff8; bo = bout8;
  endtask

  task automatic do_op4(input logic [3:0] av, input logic [3:0] bv, input logic bv_in,
                        output logic [3:0] d, output logic bo, output int lat);
    @(negedge clk);
    start4 = 1'b1; a4 = av; b4 = bv; bin4 = bv_in;
    @(negedge clk);
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
    lat = 1;
    while (done4 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    d = diff4; bo = bout4;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8: got %b expected 0", busy8); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done8: got %b expected 0", done8); end
    checks++; if (diff8 !== 8'h00) begin errors++; $display("FAIL reset_diff8: got %h expected 00", diff8); end
    checks++; if (bout8 !== 1'b0) begin errors++; $display("FAIL reset_bout8: got %b expected 0", bout8); end
    checks++; if ({busy4, done4, diff4, bout4} !== 7'd0) begin
      errors++; $display("FAIL reset_w4: got %b expected 0", {busy4, done4, diff4, bout4});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] d; logic bo; int lat, bc; bit st;
    do_op8(8'd100, 8'd37, 1'b0, d, bo, lat, bc, st);
    checks++; if (lat !== 9) begin errors++; $display("FAIL basic_latency: got %0d expected 9", lat); end
    checks++; if (bc !== 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 8", bc); end
    checks++; if (d !== 8'h3F) begin errors++; $display("FAIL basic_diff: got %h expected 3f", d); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL basic_bout: got %b expected 0", bo); end
    @(negedge clk);
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b expected 0", done8); end
    checks++; if (diff8 !== 8'h3F) begin errors++; $display("FAIL basic_diff_hold: got %h expected 3f", diff8); end
  endtask

  task automatic test_vectors();
    logic [7:0] va[3] = '{8'd5, 8'd0, 8'hFF};
    logic [7:0] vb[3] = '{8'd10, 8'd0, 8'hFF};
    logic       vi[3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] ed[3] = '{8'hFB, 8'hFF, 8'h00};
    logic       eb[3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] d; logic bo; int lat, bc; bit st;
    for (int i = 0; i < 3; i++) begin
      do_op8(va[i], vb[i], vi[i], d, bo, lat, bc, st);
      checks++; if (d !== ed[i]) begin errors++; $display("FAIL vec%0d_diff: got %h expected %h", i, d, ed[i]); end
      checks++; if (bo !== eb[i]) begin errors++; $display("FAIL vec%0d_bout: got %b expected %b", i, bo, eb[i]); end
    end
  endtask

  task automatic test_start_held();
    int lat;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd100; b8 = 8'd37; bin8 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 3) begin a8 = 8'hAA; b8 = 8'h55; end
    end while (done8 !== 1'b1 && lat < 40);
    checks++; if (lat !== 9) begin errors++; $display("FAIL held_latency: got %0d expected 9", lat); end
    checks++; if (diff8 !== 8'h3F) begin errors++; $display("FAIL held_diff: got %h expected 3f", diff8); end
    checks++; if (bout8 !== 1'b0) begin errors++; $display("FAIL held_bout: got %b expected 0", bout8); end
    @(negedge clk);
    checks++; if ({busy8, done8} !== 2'b00) begin errors++; $display("FAIL held_idle: got %b expected 00", {busy8, done8}); end
    @(negedge clk);
    checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL held_restart: got %b expected 1", busy8); end
    start8 = 1'b0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    checks++; if (diff8 !== 8'h55 || bout8 !== 1'b0) begin
      errors++; $display("FAIL held_second: got %h/%b expected 55/0", diff8, bout8);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d; logic bo; int lat, bc, seen; bit st;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd200; b8 = 8'd1; bin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({busy8, done8, diff8, bout8} !== 11'd0) begin
      errors++; $display("FAIL midreset_clear: got %b expected 0", {busy8, done8, diff8, bout8});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin @(negedge clk); if (done8 === 1'b1) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d expected 0", seen); end
    do_op8(8'd200, 8'd1, 1'b0, d, bo, lat, bc, st);
    checks++; if (d !== 8'd199 || bo !== 1'b0) begin
      errors++; $display("FAIL midreset_fresh: got %0d/%b expected 199/0", d, bo);
    end
  endtask

  task automatic test_width4();
    logic [3:0] d; logic bo; int lat;
    do_op4(4'h7, 4'h8, 1'b0, d, bo, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL w4_latency: got %0d expected 5", lat); end
    checks++; if (d !== 4'hF || bo !== 1'b1) begin errors++; $display("FAIL w4_a: got %h/%b expected f/1", d, bo); end
    do_op4(4'h8, 4'h7, 1'b1, d, bo, lat);
    checks++; if (d !== 4'h0 || bo !== 1'b0) begin errors++; $display("FAIL w4_b: got %h/%b expected 0/0", d, bo); end
    for (int i = 0; i < 20; i++) begin
      logic [3:0] x, y; logic z; logic [4:0] e;
      x = 4'($urandom); y = 4'($urandom); z = 1'($urandom);
      e = ref_sub4(x, y, z);
      do_op4(x, y, z, d, bo, lat);
      checks++; if ({bo, d} !== e) begin
        errors++; $display("FAIL w4_rand%0d: %h-%h-%b got %b/%h expected %b/%h", i, x, y, z, bo, d, e[4], e[3:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d, x, y; logic bo, z; int lat, bc, base; bit st; logic [8:0] e;
    base = done_cnt8;
    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom); y = 8'($urandom); z = 1'($urandom);
      e = ref_sub8(x, y, z);
      do_op8(x, y, z, d, bo, lat, bc, st);
      checks++; if ({bo, d} !== e) begin
        errors++; $display("FAIL rand%0d: %h-%h-%b got %b/%h expected %b/%h", i, x, y, z, bo, d, e[8], e[7:0]);
      end
      checks++; if (lat !== 9) begin errors++; $display("FAIL rand%0d_latency: got %0d expected 9", i, lat); end
      checks++; if (st !== 1'b1) begin errors++; $display("FAIL rand%0d_stable: got %b expected 1", i, st); end
    end
    @(negedge clk);
    checks++; if (done_cnt8 - base !== 1000) begin
      errors++; $display("FAIL rand_done_count: got %0d expected 1000", done_cnt8 - base);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_start_held();
    test_reset_mid();
    test_width4();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor. Computes A − B − Bin LSB-first, one bit per clock, using the full-subtractor equations on a single registered borrow. It is the inverse-operation companion to the team's dataflow full adder and is used where area matters more than latency, for example in ALU lab builds. A start/busy/done handshake drives it.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; captured on the accepted start edge
b  input  WIDTH  subtrahend; captured on the accepted start edge
bin  input  1  borrow-in; captured on the accepted start edge
busy  output  1  high while an operation is in progress (RUN state)
done  output  1  one-cycle pulse when diff/bout become valid
diff  output  WIDTH  result, (a − b − bin) mod 2^WIDTH
bout  output  1  final borrow-out; 1 when a < b + bin (unsigned)

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, diff=0, bout=0; shift registers, borrow register and bit counter cleared. Asserting reset mid-operation aborts the operation; no done pulse follows.
- State IDLE:
  - start=1 at an edge: load sa←a, sb←b, br←bin, cnt←0. Go to RUN.
  - Otherwise stay in IDLE.
- State RUN (busy=1), one bit per edge:
  - d = sa[0] ^ sb[0] ^ br
  - br ← (~sa[0] & sb[0]) | (~sa[0] & br) | (sb[0] & br)
  - sa and sb shift right by 1.
  - d shifts into the MSB of the internal result register sr (sr shifts right).
  - cnt increments each edge.
  - On the edge where cnt = WIDTH−1 (the WIDTH-th bit):
    - diff ← completed result, equal to {d, sr[WIDTH-1:1]}
    - bout ← new borrow value
    - go to DONE.
- State DONE: done=1 and busy=0 for exactly one cycle, then unconditionally return to IDLE.
- Outputs diff/bout:
  - They change only on the transition into DONE.
  - They hold their values through IDLE and the next RUN until the next completion.
  - They are never partial results.
- Latency: start sampled at edge E0 → bits processed at edges E1..E_WIDTH → done high during the cycle after E_WIDTH. The next start can be accepted at edge E_WIDTH+2 at the earliest.
- start is ignored in RUN and DONE. It is not queued and the operand inputs are not resampled.
- a, b and bin may change freely after the accepting edge.
- cnt is wide enough for WIDTH−1 (5 bits at WIDTH=32). It does not wrap during an operation.
- Arithmetic is unsigned modulo 2^WIDTH. bout=1 exactly when the true result is negative.
- All registers update on the rising edge of clk only, apart from the asynchronous reset.

Test Plan:
1. WIDTH=8, a=100, b=37, bin=0, 1-cycle start → busy high for 8 cycles; done pulses 1 cycle in the 9th cycle after the start edge; diff=63 (0x3F), bout=0.
2. WIDTH=8, a=5, b=10, bin=0 → diff=0xFB, bout=1. Then a=0, b=0, bin=1 → diff=0xFF, bout=1. Then a=0xFF, b=0xFF, bin=0 → diff=0x00, bout=0.
3. Start held high during RUN, with a and b changed mid-run to 0xAA/0x55 → first result unaffected (100−37=63); no second operation starts until after done; start still high in IDLE after DONE starts a new operation on the then-current inputs.
4. rst_n pulled low at RUN bit 4 of an operation on a=200, b=1 → busy, done, diff and bout drop to 0 immediately (asynchronous); no done pulse after release. A fresh start then yields diff=199, bout=0.
5. WIDTH=4 instance, a=4'h7, b=4'h8, bin=0 → diff=4'hF, bout=1, done 4 cycles after the start edge. Also a=4'h8, b=4'h7, bin=1 → diff=4'h0, bout=0.
6. Random regression: 1000 random a, b, bin at WIDTH=8 with back-to-back starts → diff/bout match the reference model {bout,diff} = {1'b0,a} − {1'b0,b} − bin; exactly one done per accepted start; diff stable between done pulses.
